// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: slice state encoding and occupancy decode.
package pipe_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned OCC_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    // Number of entries held in a given slice state.
    function automatic logic [OCC_W-1:0] occ_of(input state_t s);
        logic [OCC_W-1:0] occ;
        occ = OCC_W'(0);
        case (s)
            S_ONE:   occ = OCC_W'(1);
            S_TWO:   occ = OCC_W'(2);
            default: occ = OCC_W'(0);
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/data_reg.sv
// Load-enabled payload flop with asynchronous active-low reset to a fixed value.
module data_reg #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline register slice with ready/valid handshake, 2-entry skid buffer and
// synchronous flush; every output is taken straight from a flop.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       WIDTH          = 32,
    parameter logic [WIDTH-1:0]  RESET_VAL      = '0,
    parameter bit                CLEAR_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    state_t           state;
    state_t           state_nxt;
    logic             in_fire;
    logic             out_fire;
    logic             main_ld;
    logic             skid_ld;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign out_data = main_q;

    // Next state and data-register steering; flush overrides everything.
    always_comb begin
        state_nxt = state;
        main_ld   = 1'b0;
        skid_ld   = 1'b0;
        main_d    = in_data;
        skid_d    = in_data;

        unique case (state)
            S_EMPTY: begin
                if (in_fire) begin
                    state_nxt = S_ONE;
                    main_ld   = 1'b1;
                end
            end
            S_ONE: begin
                if (in_fire && out_fire) begin
                    main_ld = 1'b1;
                end else if (in_fire) begin
                    state_nxt = S_TWO;
                    skid_ld   = 1'b1;
                end else if (out_fire) begin
                    state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                // Skid entry moves up; in_ready is low so nothing new arrives.
                if (out_fire) begin
                    state_nxt = S_ONE;
                    main_ld   = 1'b1;
                    main_d    = skid_q;
                end
            end
            default: begin
                state_nxt = S_EMPTY;
            end
        endcase

        if (flush) begin
            state_nxt = S_EMPTY;
            main_ld   = CLEAR_ON_FLUSH;
            skid_ld   = CLEAR_ON_FLUSH;
            main_d    = RESET_VAL;
            skid_d    = RESET_VAL;
        end
    end

    // State and handshake outputs are registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            occupancy <= OCC_W'(0);
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt != S_EMPTY);
            in_ready  <= (state_nxt != S_TWO);
            occupancy <= occ_of(state_nxt);
        end
    end

    data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_ld),
        .d    (main_d),
        .q    (main_q)
    );

    data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_ld),
        .d    (skid_d),
        .q    (skid_q)
    );

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised pipeline register slice for the pipelined datapath. Successor to the plain 32-bit reset flop used for DR/A/B/ALUOut.
- Adds a ready/valid handshake, a 2-entry skid buffer so back-pressure is absorbed without a combinational ready path, a synchronous flush for bubbles and branch squash, and a configurable reset value.
- Sits between any two pipeline stages, e.g. IF/ID, ID/EX, EX/MEM, MEM/WB.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- RESET_VAL, 0, value of out_data after reset, and after flush when CLEAR_ON_FLUSH=1.
- CLEAR_ON_FLUSH, 1, 1 = flush also loads RESET_VAL into both data registers; 0 = data registers keep their contents, only valid state clears.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  slice can accept a beat; driven directly from a register.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid beat; registered.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  payload; registered, main entry.
- occupancy  output  2  held entries, 0..2.

Behaviour:
- Transfer rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. All outputs come from flops; no combinational in->out path.
- State machine: EMPTY (0 entries), ONE (main full), TWO (main + skid full). Outputs per state:
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO).
  - occupancy = 0/1/2.
- Reset (rst=0, asynchronous): state=EMPTY, out_valid=0, in_ready=1, occupancy=0, main=skid=RESET_VAL. No beats are accepted while rst=0.
- Transitions when flush=0:
  - EMPTY: in_fire -> ONE, main<=in_data. Otherwise stay.
  - ONE: in_fire & out_fire -> ONE, main<=in_data. in_fire only -> TWO, skid<=in_data. out_fire only -> EMPTY. Neither -> hold.
  - TWO: in_ready=0, so there is no in_fire. out_fire -> ONE, main<=skid. Otherwise hold.
- Latency: 1 cycle from in_fire to out_valid with empty slice. Full throughput (1 beat/cycle) when out_ready is held 1.
- Ordering: strictly FIFO. The skid entry is never presented before the main entry.
- Data stability: while out_valid=1 and out_ready=0, out_data and out_valid hold constant.
- Flush (highest priority, synchronous):
  - Next state is EMPTY.
  - Any in_fire in the same cycle is accepted by handshake, then discarded.
  - Any out_fire in the same cycle counts as consumed by downstream.
  - CLEAR_ON_FLUSH=1: main and skid load RESET_VAL.
  - Next cycle: out_valid=0, in_ready=1.
- Reset mid-operation: all entries are lost immediately and asynchronously. Outputs return to their reset values without waiting for clk.
- Illegal stimulus: in_valid is ignored while in_ready=0. Upstream must keep in_valid/in_data stable until accepted; the slice does not check this.
- Widths: occupancy is 2 bits and never reaches 3.

Decomposition:
- Shared pipeline package (pipe_pkg) holds the state encoding constants S_EMPTY=2'd0, S_ONE=2'd1, S_TWO=2'd2, reused by every stage register.
- Optional sub-module: data_reg (WIDTH, RESET_VAL), a load-enabled async-active-low-reset flop, instantiated twice for main and skid.
- The FSM and handshake logic stay in pipe_skid_reg.

Test Plan:
- Reset: WIDTH=32, RESET_VAL=32'hDEADBEEF, assert rst=0 mid-cycle -> immediately out_valid=0, in_ready=1, occupancy=0, out_data=32'hDEADBEEF.
- Streaming: out_ready=1, drive 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 on the following cycles, out_valid continuous, occupancy stays 1.
- Back-pressure: out_ready=0, send 0xA then 0xB -> occupancy 2, in_ready=0. 0xC held upstream is not accepted. Raise out_ready -> outputs 0xA, 0xB, 0xC in order, no loss or duplication.
- Flush while full: occupancy 2 with 0xA/0xB, pulse flush with in_valid=1, in_data=0xC -> next cycle out_valid=0, occupancy 0, out_data=RESET_VAL. 0xC never appears.
- Flush with CLEAR_ON_FLUSH=0: hold 0x55, pulse flush -> out_valid=0, out_data stays 0x55.
- Random ready/valid soak (10k cycles, WIDTH=8): scoreboard shows in-order delivery, and out_data stable while out_valid & !out_ready.
